// File: rtl/z2_cycle_sequencer_pkg.sv
// Shared encodings for the Zorro II slave cycle sequencer: bus state seen by autoconfig,
// latched target, and the bundle of active-low memory/IDE strobes.
package z2_cycle_sequencer_pkg;

  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    Z2_IDLE  = 2'd0,
    Z2_START = 2'd1,
    Z2_DATA  = 2'd2,
    Z2_END   = 2'd3
  } z2_state_e;

  typedef enum logic [2:0] {
    TGT_NONE  = 3'd0,
    TGT_AC    = 3'd1,
    TGT_RAM   = 3'd2,
    TGT_IDE   = 3'd3,
    TGT_CTRL  = 3'd4,
    TGT_FLASH = 3'd5
  } z2_target_e;

  typedef struct packed {
    logic       ram_oe_n;
    logic [1:0] ram_we_n;
    logic       flash_oe_n;
    logic       flash_we_n;
    logic       ide_rd_n;
    logic       ide_wr_n;
  } z2_strobes_t;

  localparam z2_strobes_t STROBES_OFF = '1;

  // Overlapping decodes should never happen; the fixed order just keeps behaviour defined.
  function automatic z2_target_e pick_target(input logic ac, input logic ram, input logic ide,
                                             input logic ctrl, input logic flash);
    if (ac)         return TGT_AC;
    else if (ram)   return TGT_RAM;
    else if (ide)   return TGT_IDE;
    else if (ctrl)  return TGT_CTRL;
    else if (flash) return TGT_FLASH;
    else            return TGT_NONE;
  endfunction

  function automatic z2_strobes_t drop_writes(input z2_strobes_t s);
    z2_strobes_t r;
    r            = s;
    r.ram_we_n   = 2'b11;
    r.flash_we_n = 1'b1;
    r.ide_wr_n   = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/z2_cycle_sequencer_sync2.sv
// Two-flop synchroniser for one asynchronous input; RESET_VAL is the inactive level.
module z2_cycle_sequencer_sync2 #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RESET,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/z2_cycle_sequencer.sv
// Zorro II slave bus-cycle sequencer: tracks one 68000 cycle through IDLE/START/DATA/END and
// drives per-target strobes, wait states, DTACK and a DATA-phase timeout.
module z2_cycle_sequencer #(
  parameter int unsigned RAM_WAIT   = 0,
  parameter int unsigned FLASH_WAIT = 2,
  parameter int unsigned IDE_WAIT   = 3,
  parameter int unsigned CTRL_WAIT  = 0,
  parameter int unsigned TIMEOUT    = 63
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       AS_n,
  input  logic       UDS_n,
  input  logic       LDS_n,
  input  logic       RW,
  input  logic       IDE_IORDY,
  input  logic       ram_access,
  input  logic       flash_access,
  input  logic       ide_access,
  input  logic       ctrl_access,
  input  logic       autoconfig_cycle,
  input  logic       ac_dtack,
  output logic [1:0] z2_state,
  output logic       dtack,
  output logic       ram_oe_n,
  output logic [1:0] ram_we_n,
  output logic       flash_oe_n,
  output logic       flash_we_n,
  output logic       ide_rd_n,
  output logic       ide_wr_n,
  output logic       ctrl_wr,
  output logic       timeout
);

  import z2_cycle_sequencer_pkg::*;

  localparam logic [CNT_W-1:0] RAM_W   = CNT_W'(RAM_WAIT);
  localparam logic [CNT_W-1:0] FLASH_W = CNT_W'(FLASH_WAIT);
  localparam logic [CNT_W-1:0] IDE_W   = CNT_W'(IDE_WAIT);
  localparam logic [CNT_W-1:0] CTRL_W  = CNT_W'(CTRL_WAIT);
  localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);

  logic as_n_s, uds_n_s, lds_n_s, iordy_s;
  logic as_s, uds_s, lds_s;

  z2_cycle_sequencer_sync2 #(.RESET_VAL(1'b1)) u_sync_as (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (AS_n),
    .q     (as_n_s)
  );

  z2_cycle_sequencer_sync2 #(.RESET_VAL(1'b1)) u_sync_uds (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (UDS_n),
    .q     (uds_n_s)
  );

  z2_cycle_sequencer_sync2 #(.RESET_VAL(1'b1)) u_sync_lds (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (LDS_n),
    .q     (lds_n_s)
  );

  z2_cycle_sequencer_sync2 #(.RESET_VAL(1'b0)) u_sync_iordy (
    .CLK   (CLK),
    .RESET (RESET),
    .d     (IDE_IORDY),
    .q     (iordy_s)
  );

  assign as_s  = ~as_n_s;
  assign uds_s = ~uds_n_s;
  assign lds_s = ~lds_n_s;

  z2_state_e        state_q;
  z2_target_e       target_q;
  logic             rw_q;
  logic             armed_q;
  logic [CNT_W-1:0] wcnt_q;
  logic [CNT_W-1:0] tcnt_q;
  z2_strobes_t      strobes_q;
  logic             dtack_q;
  logic             ctrl_wr_q;
  logic             timeout_q;

  z2_target_e       tgt_sel;
  z2_target_e       cur_tgt;
  logic             cur_rw;
  z2_strobes_t      act_strobes;
  logic             tgt_valid;
  logic             wait_zero;
  logic             normal_done;
  logic             force_done;
  logic [CNT_W-1:0] tcnt_inc;

  function automatic logic [CNT_W-1:0] wait_for(input z2_target_e t);
    case (t)
      TGT_RAM:   return RAM_W;
      TGT_FLASH: return FLASH_W;
      TGT_IDE:   return IDE_W;
      TGT_CTRL:  return CTRL_W;
      default:   return '0;
    endcase
  endfunction

  // In IDLE the strobes are built from the live decode so they are already valid in START.
  always_comb begin
    tgt_sel     = pick_target(autoconfig_cycle, ram_access, ide_access, ctrl_access,
                              flash_access);
    cur_tgt     = (state_q == Z2_IDLE) ? tgt_sel : target_q;
    cur_rw      = (state_q == Z2_IDLE) ? RW : rw_q;
    act_strobes = STROBES_OFF;
    case (cur_tgt)
      TGT_RAM: begin
        if (cur_rw) act_strobes.ram_oe_n = 1'b0;
        else        act_strobes.ram_we_n = {~uds_s, ~lds_s};
      end
      TGT_FLASH: begin
        if (cur_rw) act_strobes.flash_oe_n = 1'b0;
        else        act_strobes.flash_we_n = 1'b0;
      end
      TGT_IDE: begin
        if (cur_rw) act_strobes.ide_rd_n = 1'b0;
        else        act_strobes.ide_wr_n = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    wait_zero   = (wcnt_q == '0);
    tcnt_inc    = (tcnt_q == '1) ? tcnt_q : tcnt_q + CNT_ONE;
    force_done  = (tcnt_inc == TO_LIM);
    normal_done = 1'b0;
    tgt_valid   = 1'b1;
    case (target_q)
      TGT_AC:                      normal_done = ac_dtack;
      TGT_IDE:                     normal_done = wait_zero && iordy_s;
      TGT_RAM, TGT_FLASH, TGT_CTRL: normal_done = wait_zero;
      default:                     tgt_valid   = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= Z2_IDLE;
      target_q  <= TGT_NONE;
      rw_q      <= 1'b1;
      armed_q   <= 1'b0;
      wcnt_q    <= '0;
      tcnt_q    <= '0;
      strobes_q <= STROBES_OFF;
      dtack_q   <= 1'b0;
      ctrl_wr_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      ctrl_wr_q <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state_q)
        Z2_IDLE: begin
          dtack_q   <= 1'b0;
          strobes_q <= STROBES_OFF;
          // A new cycle is only accepted after AS has been seen idle here.
          if (!as_s) begin
            armed_q <= 1'b1;
          end else if (armed_q && (tgt_sel != TGT_NONE)) begin
            armed_q   <= 1'b0;
            target_q  <= tgt_sel;
            rw_q      <= RW;
            strobes_q <= act_strobes;
            state_q   <= Z2_START;
          end
        end
        Z2_START: begin
          if (!as_s || !tgt_valid) begin
            state_q   <= Z2_IDLE;
            target_q  <= TGT_NONE;
            strobes_q <= STROBES_OFF;
          end else begin
            wcnt_q    <= wait_for(target_q);
            tcnt_q    <= '0;
            strobes_q <= act_strobes;
            state_q   <= Z2_DATA;
          end
        end
        Z2_DATA: begin
          if (!as_s || !tgt_valid) begin
            state_q   <= Z2_IDLE;
            target_q  <= TGT_NONE;
            strobes_q <= STROBES_OFF;
          end else if (normal_done || force_done) begin
            state_q   <= Z2_END;
            strobes_q <= drop_writes(strobes_q);
            dtack_q   <= (target_q != TGT_AC);
            ctrl_wr_q <= (target_q == TGT_CTRL) && !rw_q;
            timeout_q <= !normal_done;
          end else begin
            if (!wait_zero) wcnt_q <= wcnt_q - CNT_ONE;
            tcnt_q    <= tcnt_inc;
            strobes_q <= act_strobes;
          end
        end
        Z2_END: begin
          if (!as_s || !tgt_valid) begin
            state_q   <= Z2_IDLE;
            target_q  <= TGT_NONE;
            strobes_q <= STROBES_OFF;
            dtack_q   <= 1'b0;
          end
        end
      endcase
    end
  end

  assign z2_state   = state_q;
  assign dtack      = dtack_q;
  assign ram_oe_n   = strobes_q.ram_oe_n;
  assign ram_we_n   = strobes_q.ram_we_n;
  assign flash_oe_n = strobes_q.flash_oe_n;
  assign flash_we_n = strobes_q.flash_we_n;
  assign ide_rd_n   = strobes_q.ide_rd_n;
  assign ide_wr_n   = strobes_q.ide_wr_n;
  assign ctrl_wr    = ctrl_wr_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_z2_cycle_sequencer.sv
// Randomized bench for z2_cycle_sequencer: each bus cycle is predicted from its target, wait
// states, IORDY/ac_dtack timing and abort point, then checked cycle by cycle.
module tb_z2_cycle_sequencer;

  localparam int RamWait   = 0;
  localparam int FlashWait = 2;
  localparam int IdeWait   = 3;
  localparam int CtrlWait  = 0;
  localparam int Timeout   = 63;
  localparam int Inf       = 1000;

  localparam int TgtNone  = 0;
  localparam int TgtAc    = 1;
  localparam int TgtRam   = 2;
  localparam int TgtIde   = 3;
  localparam int TgtCtrl  = 4;
  localparam int TgtFlash = 5;

  localparam logic [1:0] SIdle  = 2'd0;
  localparam logic [1:0] SStart = 2'd1;
  localparam logic [1:0] SData  = 2'd2;
  localparam logic [1:0] SEnd   = 2'd3;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       AS_n = 1'b1, UDS_n = 1'b1, LDS_n = 1'b1, RW = 1'b1, IDE_IORDY = 1'b0;
  logic       ram_access = 1'b0, flash_access = 1'b0, ide_access = 1'b0;
  logic       ctrl_access = 1'b0, autoconfig_cycle = 1'b0, ac_dtack = 1'b0;
  logic [1:0] z2_state;
  logic       dtack, ram_oe_n, flash_oe_n, flash_we_n, ide_rd_n, ide_wr_n, ctrl_wr, timeout;
  logic [1:0] ram_we_n;
  logic [6:0] strobes;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  assign strobes = {ram_oe_n, ram_we_n, flash_oe_n, flash_we_n, ide_rd_n, ide_wr_n};

  z2_cycle_sequencer dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .AS_n             (AS_n),
    .UDS_n            (UDS_n),
    .LDS_n            (LDS_n),
    .RW               (RW),
    .IDE_IORDY        (IDE_IORDY),
    .ram_access       (ram_access),
    .flash_access     (flash_access),
    .ide_access       (ide_access),
    .ctrl_access      (ctrl_access),
    .autoconfig_cycle (autoconfig_cycle),
    .ac_dtack         (ac_dtack),
    .z2_state         (z2_state),
    .dtack            (dtack),
    .ram_oe_n         (ram_oe_n),
    .ram_we_n         (ram_we_n),
    .flash_oe_n       (flash_oe_n),
    .flash_we_n       (flash_we_n),
    .ide_rd_n         (ide_rd_n),
    .ide_wr_n         (ide_wr_n),
    .ctrl_wr          (ctrl_wr),
    .timeout          (timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_state"}, z2_state, SIdle);
    check_eq({tag, "_dtack"}, dtack, 1'b0);
    check_eq({tag, "_strobes"}, strobes, 7'h7f);
    check_eq({tag, "_ctrl_wr"}, ctrl_wr, 1'b0);
    check_eq({tag, "_timeout"}, timeout, 1'b0);
  endtask

  task automatic release_bus();
    AS_n  = 1'b1;
    UDS_n = 1'b1;
    LDS_n = 1'b1;
  endtask

  task automatic clear_decodes();
    {flash_access, ctrl_access, ide_access, ram_access, autoconfig_cycle} = 5'b0;
    ac_dtack = 1'b0;
  endtask

  // dec bits: [0]=autoconfig, [1]=ram, [2]=ide, [3]=ctrl, [4]=flash
  function automatic int tgt_of(input logic [4:0] dec);
    if (dec[0]) return TgtAc;
    if (dec[1]) return TgtRam;
    if (dec[2]) return TgtIde;
    if (dec[3]) return TgtCtrl;
    if (dec[4]) return TgtFlash;
    return TgtNone;
  endfunction

  function automatic logic [6:0] exp_strobes(input int tgt, input bit rw, input logic [1:0] ds_n,
                                             input bit writes);
    logic       oe_r, oe_f, we_f, rd_i, wr_i;
    logic [1:0] we_r;
    oe_r = 1'b1; we_r = 2'b11; oe_f = 1'b1; we_f = 1'b1; rd_i = 1'b1; wr_i = 1'b1;
    if (tgt == TgtRam)   begin if (rw) oe_r = 1'b0; else if (writes) we_r = ds_n; end
    if (tgt == TgtFlash) begin if (rw) oe_f = 1'b0; else if (writes) we_f = 1'b0; end
    if (tgt == TgtIde)   begin if (rw) rd_i = 1'b0; else if (writes) wr_i = 1'b0; end
    return {oe_r, we_r, oe_f, we_f, rd_i, wr_i};
  endfunction

  // rdy: -1 = IORDY already high, Inf = stuck low, else raised in that DATA cycle.
  // acat: DATA cycle in which ac_dtack pulses (Inf = never). abrt_in: DATA cycle AS_n rises.
  task automatic run_txn(input logic [4:0] dec, input bit rw, input logic [1:0] ds_n,
                         input int rdy, input int acat, input int abrt_in, input int hold);
    int tgt, w, d, dd, abrt, ndata, t_end, t_idle, k;
    bit forced, aborted;
    logic [1:0] exp_st;
    tgt = tgt_of(dec);
    {flash_access, ctrl_access, ide_access, ram_access, autoconfig_cycle} = dec;
    RW        = rw;
    IDE_IORDY = (rdy < 0);
    ac_dtack  = 1'b0;
    AS_n      = 1'b0;
    UDS_n     = ds_n[1];
    LDS_n     = ds_n[0];
    if (tgt == TgtNone) begin
      for (int i = 0; i < 6; i++) begin
        @(negedge CLK);
        check_eq("foreign_state", z2_state, SIdle);
        check_eq("foreign_strobes", strobes, 7'h7f);
      end
      release_bus();
      repeat (3) @(negedge CLK);
      clear_decodes();
      return;
    end
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (z2_state != SStart && k < 8);
    check_eq("start_latency", k, 3);
    if (z2_state != SStart) begin
      release_bus();
      repeat (4) @(negedge CLK);
      clear_decodes();
      return;
    end

    case (tgt)
      TgtRam:   w = RamWait;
      TgtFlash: w = FlashWait;
      TgtIde:   w = IdeWait;
      TgtCtrl:  w = CtrlWait;
      default:  w = 0;
    endcase
    if (tgt == TgtAc)       d = acat;
    else if (tgt == TgtIde) d = (rdy < 0) ? w : (rdy >= Inf) ? Inf : ((rdy + 2 > w) ? rdy + 2 : w);
    else                    d = w;
    forced  = (d > Timeout - 1);
    dd      = forced ? Timeout - 1 : d;
    abrt    = (abrt_in >= 0 && abrt_in + 2 <= dd) ? abrt_in : -1;
    aborted = (abrt >= 0);
    ndata   = aborted ? abrt + 3 : dd + 1;
    t_end   = ndata + 1;
    t_idle  = aborted ? ndata + 1 : t_end + hold + 3;

    for (int t = 0; t <= t_idle; t++) begin
      if (t == 0)           exp_st = SStart;
      else if (t <= ndata)  exp_st = SData;
      else if (t == t_idle) exp_st = SIdle;
      else                  exp_st = SEnd;
      check_eq("state", z2_state, exp_st);
      if (exp_st == SIdle)     check_eq("strobes_idle", strobes, 7'h7f);
      else if (exp_st == SEnd) check_eq("strobes_end", strobes, exp_strobes(tgt, rw, ds_n, 1'b0));
      else                     check_eq("strobes_act", strobes, exp_strobes(tgt, rw, ds_n, 1'b1));
      check_eq("dtack", dtack, (exp_st == SEnd) && (tgt != TgtAc));
      check_eq("ctrl_wr", ctrl_wr, (t == t_end) && !aborted && (tgt == TgtCtrl) && !rw);
      check_eq("timeout", timeout, (t == t_end) && !aborted && forced);
      ac_dtack = (tgt == TgtAc) && (t == 1 + acat);
      if (tgt == TgtIde && rdy >= 0 && t == 1 + rdy) IDE_IORDY = 1'b1;
      if (aborted && t == 1 + abrt) release_bus();
      if (!aborted && t == t_end + hold) release_bus();
      @(negedge CLK);
    end
    clear_decodes();
  endtask

  task automatic reset_in_end();
    int k;
    ram_access = 1'b1;
    RW         = 1'b1;
    UDS_n      = 1'b0;
    LDS_n      = 1'b0;
    AS_n       = 1'b0;
    k = 0;
    do begin
      @(negedge CLK);
      k++;
    end while (z2_state != SEnd && k < 12);
    check_eq("pre_reset_state", z2_state, SEnd);
    check_eq("pre_reset_dtack", dtack, 1'b1);
    check_eq("pre_reset_oe", ram_oe_n, 1'b0);
    RESET = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    @(negedge CLK);
    RESET = 1'b0;
    release_bus();
    clear_decodes();
    repeat (4) @(negedge CLK);
    check_eq("post_reset_state", z2_state, SIdle);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion",
             n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] dec;
    logic [1:0] ds_n;
    int         p, rdy, acat, abrt;
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    check_idle_outputs("reset");
    RESET = 1'b0;
    repeat (3) @(negedge CLK);

    run_txn(5'b00010, 1'b1, 2'b00, -1, 0, -1, 1);   // RAM read
    run_txn(5'b00010, 1'b0, 2'b01, -1, 0, -1, 0);   // RAM upper-byte write
    run_txn(5'b00100, 1'b1, 2'b00, 10, 0, -1, 1);   // IDE read, IORDY late
    run_txn(5'b00100, 1'b1, 2'b00, Inf, 0, -1, 2);  // IDE stuck: timeout
    run_txn(5'b00100, 1'b0, 2'b00, 60, 0, -1, 0);   // completes on the timeout cycle
    run_txn(5'b00001, 1'b0, 2'b00, -1, 3, -1, 0);   // autoconfig write
    run_txn(5'b10000, 1'b0, 2'b00, -1, 0, 0, 0);    // flash write aborted in DATA
    run_txn(5'b01000, 1'b0, 2'b00, -1, 0, -1, 1);   // control-register write
    run_txn(5'b00000, 1'b1, 2'b00, -1, 0, -1, 0);   // not our cycle
    reset_in_end();

    for (int n = 0; n < 120; n++) begin
      p = $urandom_range(0, 99);
      if (p < 8)       dec = 5'b0;
      else if (p < 18) dec = 5'($urandom_range(1, 31));
      else             dec = 5'b1 << $urandom_range(0, 4);
      p = $urandom_range(0, 2);
      ds_n = (p == 0) ? 2'b00 : (p == 1) ? 2'b01 : 2'b10;
      p = $urandom_range(0, 19);
      if (p < 4)       rdy = -1;
      else if (p == 4) rdy = Inf;
      else if (p < 7)  rdy = $urandom_range(58, 63);
      else             rdy = $urandom_range(0, 12);
      acat = ($urandom_range(0, 19) == 0) ? Inf : $urandom_range(0, 8);
      abrt = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 6) : -1;
      run_txn(dec, 1'($urandom_range(0, 1)), ds_n, rdy, acat, abrt, $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
